lbp_hist: RTL and testbench
===========================

LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 The block SHALL have these parameters: none; bin count fixed at 256 and count width fixed at 14 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 lbp_valid  input  1  one-cycle strobe from the LBP stage; lbp_data is valid when high.
REQ-005 lbp_data  input  8  LBP code of the current pixel, used as the bin index.
REQ-006 finish  input  1  one-cycle strobe from the LBP stage marking the end of the image.
REQ-007 hist_valid  output  1  a histogram bin is presented on hist_bin/hist_count.
REQ-008 hist_ready  input  1  downstream accepts the presented bin when high together with hist_valid.
REQ-009 hist_bin  output  8  index of the presented bin.
REQ-010 hist_count  output  14  count of the presented bin.
REQ-011 hist_done  output  1  one-cycle pulse after bin 255 is accepted.
REQ-012 busy  output  1  high while in DRAIN; LBP input is ignored while high.

Function
REQ-013 The block SHALL hold 256 counters of 14 bits each, plus a state register with states ACC, DRAIN, DONE.
REQ-014 In ACC, each cycle with lbp_valid=1, counter[lbp_data] SHALL increment by 1 at the next edge.
REQ-015 A counter at 16383 SHALL saturate and not wrap (126x126=15876 pixels never reaches this; saturation is defensive).
REQ-016 Back-to-back lbp_valid on the same or different bins SHALL each be counted, with no lost increments.
REQ-017 ACC->DRAIN SHALL occur on finish=1; if lbp_valid=1 in the same cycle, that sample SHALL still be counted.
REQ-018 On entry to DRAIN, the read pointer SHALL be 0; hist_valid=1, hist_bin=pointer, hist_count=counter[pointer] (combinational read).
REQ-019 In DRAIN, when hist_valid and hist_ready are both 1, the pointer SHALL advance by 1; otherwise hist_bin and hist_count SHALL stay stable.
REQ-020 In DRAIN, an accept of bin 255 SHALL move the state to DONE; the pointer SHALL not wrap to 0 while still in DRAIN.
REQ-021 In DRAIN, lbp_valid and finish SHALL be ignored, with no counter change.
REQ-022 In DONE (one cycle), hist_done=1, hist_valid=0, all 256 counters SHALL clear to 0 at the edge, and the next state SHALL be ACC.
REQ-023 lbp_valid in the DONE cycle SHALL be ignored.
REQ-024 With hist_ready held at 1, the minimum drain latency SHALL be 256 cycles of hist_valid followed by 1 cycle of hist_done.
REQ-025 busy SHALL be 1 exactly in DRAIN; hist_valid SHALL be 1 exactly in DRAIN.

Reset
REQ-026 While reset=1 (asynchronous): state=ACC, all counters=0, pointer=0.
REQ-027 While reset=1, the outputs SHALL be hist_valid=0, hist_done=0, busy=0, hist_bin=0, hist_count=0.
REQ-028 A reset asserted mid-DRAIN or mid-ACC SHALL abandon the operation and discard the partial histogram.
REQ-029 After reset is released, the first edge SHALL resume in ACC.

Verification
REQ-030 Stream of 15876 lbp_valid pulses with data=i mod 256, then finish, hist_ready=1 -> bins 0..3 read 63 and bins 4..255 read 62, in order 0..255, then one hist_done pulse.
REQ-031 lbp_valid with data=0x5A in the same cycle as finish, after 3 prior 0x5A samples -> bin 0x5A reads 4.
REQ-032 hist_ready toggled randomly during drain -> each bin is presented stable until accepted, no bin skipped or repeated, hist_done occurs once after bin 255.
REQ-033 lbp_valid pulses during DRAIN and in the DONE cycle -> no count change; the second image histogram starts from all zeros.
REQ-034 Reset asserted at drain bin 100 -> outputs go to 0 immediately; a new image then accumulates from zero.
REQ-035 20000 samples of data=0xFF (forced) -> bin 255 reads 16383 (saturated) and the other bins read 0.

Source files
------------

// File: rtl/lbp_hist.sv
// LBP code histogram: 256 saturating 14-bit bins accumulated per image, then
// drained bin by bin over a valid/ready port and cleared for the next image.
module lbp_hist (
    input  logic        clk,
    input  logic        reset,
    input  logic        lbp_valid,
    input  logic [7:0]  lbp_data,
    input  logic        finish,
    output logic        hist_valid,
    input  logic        hist_ready,
    output logic [7:0]  hist_bin,
    output logic [13:0] hist_count,
    output logic        hist_done,
    output logic        busy
);

    localparam int unsigned NUM_BINS = 256;
    localparam int unsigned BIN_W    = 8;
    localparam int unsigned CNT_W    = 14;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [BIN_W-1:0] LAST_BIN = '1;

    typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  counts [NUM_BINS];
    logic [BIN_W-1:0]  ptr;
    logic              count_en;
    logic              accept;
    logic              clear_all;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACC;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        count_en   = 1'b0;
        accept     = 1'b0;
        clear_all  = 1'b0;
        hist_valid = 1'b0;
        hist_done  = 1'b0;
        busy       = 1'b0;
        case (state)
            ACC: begin
                // a sample arriving with finish is still counted
                count_en = lbp_valid;
                if (finish) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                hist_valid = 1'b1;
                busy       = 1'b1;
                accept     = hist_ready;
                if (hist_ready && (ptr == LAST_BIN)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                hist_done  = 1'b1;
                clear_all  = 1'b1;
                next_state = ACC;
            end
            default: begin
                next_state = ACC;
            end
        endcase
    end

    // Bin counters: saturate at all-ones, cleared after each drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_BINS); i++) begin
                counts[i] <= '0;
            end
        end else if (clear_all) begin
            for (int i = 0; i < int'(NUM_BINS); i++) begin
                counts[i] <= '0;
            end
        end else if (count_en && (counts[lbp_data] != CNT_MAX)) begin
            counts[lbp_data] <= counts[lbp_data] + CNT_W'(1);
        end
    end

    // Read pointer parks on the last bin until DONE clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clear_all) begin
            ptr <= '0;
        end else if (accept && (ptr != LAST_BIN)) begin
            ptr <= ptr + BIN_W'(1);
        end
    end

    assign hist_bin   = hist_valid ? ptr : '0;
    assign hist_count = hist_valid ? counts[ptr] : '0;

endmodule

// File: tb/tb_lbp_hist.sv
// Self-checking bench for lbp_hist: table-driven image, random images against
// a histogram model, saturation, noise during drain and reset mid-drain.
module tb_lbp_hist;

    logic        clk = 1'b0;
    logic        reset;
    logic        lbp_valid;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        hist_valid;
    logic        hist_ready;
    logic [7:0]  hist_bin;
    logic [13:0] hist_count;
    logic        hist_done;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int exp_hist [256];

    typedef struct {
        logic [7:0] code;
        int         reps;
        int         exp_count;
    } vec_t;
    vec_t vecs [6];

    lbp_hist dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .hist_done  (hist_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [7:0] d, input logic f);
        lbp_valid = v;
        lbp_data  = d;
        finish    = f;
        step();
        lbp_valid = 1'b0;
        finish    = 1'b0;
    endtask

    task automatic clear_model();
        for (int b = 0; b < 256; b++) exp_hist[b] = 0;
    endtask

    task automatic model_add(input logic [7:0] d);
        if (exp_hist[d] < 16383) exp_hist[d] = exp_hist[d] + 1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(hist_valid), 0);
        chk({tag, "_done"},  32'(hist_done), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_bin"},   32'(hist_bin), 0);
        chk({tag, "_count"}, 32'(hist_count), 0);
    endtask

    // Random image: gapped samples, last cycle carries finish
    task automatic random_image(input int n);
        for (int i = 0; i < n; i++) begin
            logic       v;
            logic [7:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            if (v) model_add(d);
            put(v, d, 1'(i == n - 1));
        end
    endtask

    // Entered one step after the finish edge; expects bins 0..255 against exp_hist
    task automatic drain(input bit rnd_ready, input bit noise, input int stop_at);
        int nb     = 0;
        int cycles = 0;
        while (nb < 256 && nb != stop_at && cycles < 4000) begin
            hist_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                lbp_valid = 1'($urandom_range(0, 1));
                lbp_data  = 8'($urandom);
                finish    = 1'($urandom_range(0, 1));
            end
            #1;
            chk("drain_valid", 32'(hist_valid), 1);
            chk("drain_busy",  32'(busy), 1);
            chk("drain_bin",   32'(hist_bin), 32'(nb));
            chk("drain_count", 32'(hist_count), 32'(exp_hist[nb]));
            if (hist_ready) nb++;
            step();
            cycles++;
        end
        hist_ready = 1'b0;
        lbp_valid  = 1'b0;
        finish     = 1'b0;
        if (nb == stop_at) return;
        chk("drain_complete", 32'(nb), 256);
        if (!rnd_ready) chk("drain_cycles", 32'(cycles), 256);
        chk("done_pulse", 32'(hist_done), 1);
        chk("done_valid", 32'(hist_valid), 0);
        chk("done_busy",  32'(busy), 0);
        if (noise) begin
            lbp_valid = 1'b1;
            lbp_data  = 8'($urandom);
        end
        step();
        lbp_valid = 1'b0;
        chk("done_once", 32'(hist_done), 0);
        chk("acc_busy",  32'(busy), 0);
        clear_model();
    endtask

    initial begin
        reset      = 1'b1;
        lbp_valid  = 1'b0;
        lbp_data   = '0;
        finish     = 1'b0;
        hist_ready = 1'b0;
        clear_model();

        vecs[0] = '{code: 8'h00, reps: 1, exp_count: 1};
        vecs[1] = '{code: 8'h11, reps: 0, exp_count: 0};
        vecs[2] = '{code: 8'hFF, reps: 7, exp_count: 7};
        vecs[3] = '{code: 8'h10, reps: 3, exp_count: 3};
        vecs[4] = '{code: 8'h81, reps: 2, exp_count: 2};
        vecs[5] = '{code: 8'h5A, reps: 4, exp_count: 4};

        step();
        step();
        chk_idle_outputs("reset");
        reset = 1'b0;
        step();
        chk_idle_outputs("post_reset");

        // Table image; final 0x5A sample shares its cycle with finish
        for (int v = 0; v < 6; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                put(1'b1, vecs[v].code, 1'(v == 5 && r == vecs[v].reps - 1));
            end
        end
        for (int v = 0; v < 6; v++) exp_hist[vecs[v].code] = vecs[v].exp_count;
        drain(1'b0, 1'b0, -1);

        // Random image, random backpressure, noise during drain and DONE
        random_image(700);
        drain(1'b1, 1'b1, -1);

        // Second image must start from zero after the noisy drain
        random_image(300);
        drain(1'b0, 1'b0, -1);

        // Full 126x126 ramp image
        for (int i = 0; i < 15876; i++) put(1'b1, 8'(i), 1'(i == 15875));
        for (int b = 0; b < 256; b++) exp_hist[b] = (b < 4) ? 63 : 62;
        drain(1'b0, 1'b0, -1);

        // Saturation of bin 255
        for (int i = 0; i < 20000; i++) put(1'b1, 8'hFF, 1'b0);
        put(1'b0, 8'h00, 1'b1);
        exp_hist[255] = 16383;
        drain(1'b0, 1'b0, -1);

        // Reset while bin 100 is presented
        random_image(400);
        drain(1'b0, 1'b0, 100);
        #2;
        reset = 1'b1;
        #1;
        chk_idle_outputs("mid_drain_reset");
        step();
        reset = 1'b0;
        clear_model();
        step();
        chk_idle_outputs("after_reset");
        random_image(250);
        drain(1'b1, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
